sw_array_ctrl: RTL and testbench

- Sequencer for a linear systolic array of NUM_PE Smith-Waterman PEs.
- Loads a query (s) sequence into the per-PE s inputs and builds the active-PE mask.
- Streams target (t) bases into PE0 as one contiguous valid burst, then waits for the wavefront to drain.
- Accumulates the running maximum score from the last PE's max chain and returns it through a result handshake.

---
 rtl/sw_array_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_sw_array_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_array_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sw_array_ctrl
//  Purpose  : Job sequencer for a linear systolic array of Smith-Waterman PEs.
//             Loads the query into per-PE s registers and builds the active-PE
//             mask. It then streams the target into PE0 as one unbroken burst,
//             waits for the wavefront to drain, and returns the best score seen
//             on the last PE's max chain.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             start, len_s, len_t   - job request and lengths (IDLE only)
//             busy                  - high whenever not IDLE
//             q_valid/q_ready/q_base- query base stream (LOAD only)
//             t_valid/t_ready/t_base- target base stream (STREAM only)
//             arr_s, arr_active     - per-PE query base and active mask
//             arr_valid, arr_t      - valid_in / t_in of PE0
//             arr_max               - max_out of the last PE
//             result_valid/ready    - result handshake
//             result_max, result_err- best score, abort/invalid flag
//  Revision : 1.0 - initial release
// ============================================================================
module sw_array_ctrl #(
  parameter int NUM_PE     = 16,
  parameter int BP_WIDTH   = 2,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         len_s,
  input  logic [LEN_WIDTH-1:0]         len_t,
  output logic                         busy,
  input  logic                         q_valid,
  output logic                         q_ready,
  input  logic [BP_WIDTH-1:0]          q_base,
  input  logic                         t_valid,
  output logic                         t_ready,
  input  logic [BP_WIDTH-1:0]          t_base,
  output logic [NUM_PE*BP_WIDTH-1:0]   arr_s,
  output logic [NUM_PE-1:0]            arr_active,
  output logic                         arr_valid,
  output logic [BP_WIDTH-1:0]          arr_t,
  input  logic [DATA_WIDTH-1:0]        arr_max,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [DATA_WIDTH-1:0]        result_max,
  output logic                         result_err
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] NUM_PE_LEN = LEN_WIDTH'(NUM_PE);
  // DRAIN lasts NUM_PE+2 cycles: counter runs 0 .. NUM_PE+1
  localparam logic [LEN_WIDTH-1:0] DRAIN_LAST = LEN_WIDTH'(NUM_PE + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ARM    = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LEN_WIDTH-1:0]  len_s_q;
  logic [LEN_WIDTH-1:0]  len_t_q;
  logic [LEN_WIDTH-1:0]  qcnt;
  logic [LEN_WIDTH-1:0]  tcnt;
  logic [LEN_WIDTH-1:0]  dcnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_nxt;
  logic                  err;
  logic [NUM_PE-1:0]     active_mask;

  logic start_ok;
  logic q_fire;
  logic last_q;
  logic t_fire;
  logic last_t;
  logic bubble;
  logic drain_done;

  assign start_ok   = (len_s != '0) && (len_s <= NUM_PE_LEN) && (len_t != '0);
  assign q_fire     = (state == S_LOAD) && q_valid;
  assign last_q     = q_fire && (qcnt == len_s_q - LEN_ONE);
  assign t_fire     = (state == S_STREAM) && t_valid;
  assign last_t     = t_fire && (tcnt == len_t_q - LEN_ONE);
  // The array cannot stall, so any gap in the target burst aborts the job
  assign bubble     = (state == S_STREAM) && !t_valid;
  assign drain_done = (state == S_DRAIN) && (dcnt == DRAIN_LAST);
  assign acc_nxt    = (arr_max > acc) ? arr_max : acc;

  // PE i is active when i < len_s
  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_mask
    localparam logic [LEN_WIDTH-1:0] IDX = LEN_WIDTH'(gi);
    assign active_mask[gi] = (IDX < len_s_q);
  end

  assign q_ready      = (state == S_LOAD);
  assign t_ready      = (state == S_STREAM);
  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = start_ok ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        if (last_q) begin
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (last_t || bubble) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_s_q    <= '0;
      len_t_q    <= '0;
      qcnt       <= '0;
      tcnt       <= '0;
      dcnt       <= '0;
      acc        <= '0;
      err        <= 1'b0;
      arr_s      <= '0;
      arr_active <= '0;
      arr_valid  <= 1'b0;
      arr_t      <= '0;
      result_max <= '0;
      result_err <= 1'b0;
    end else begin
      // PE0 input is the accepted target beat delayed by one register stage
      arr_valid <= t_fire;
      if (t_fire) begin
        arr_t <= t_base;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            acc        <= '0;
            result_max <= '0;
            if (start_ok) begin
              len_s_q    <= len_s;
              len_t_q    <= len_t;
              qcnt       <= '0;
              tcnt       <= '0;
              dcnt       <= '0;
              err        <= 1'b0;
              result_err <= 1'b0;
              arr_s      <= '0;
              arr_active <= '0;
            end else begin
              err        <= 1'b1;
              result_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (q_fire) begin
            for (int i = 0; i < NUM_PE; i++) begin
              if (qcnt == LEN_WIDTH'(i)) begin
                arr_s[i*BP_WIDTH +: BP_WIDTH] <= q_base;
              end
            end
            qcnt <= qcnt + LEN_ONE;
          end
          // Mask is in place for the ARM cycle and held until the next job
          if (last_q) begin
            arr_active <= active_mask;
          end
        end
        S_STREAM: begin
          acc <= acc_nxt;
          if (t_fire) begin
            tcnt <= tcnt + LEN_ONE;
          end
          if (bubble) begin
            err <= 1'b1;
          end
        end
        S_DRAIN: begin
          acc  <= acc_nxt;
          dcnt <= dcnt + LEN_ONE;
          // Include the final drain sample in the reported score
          if (drain_done) begin
            result_max <= acc_nxt;
            result_err <= err;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sw_array_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sw_array_ctrl
//  Purpose  : Self-checking bench for sw_array_ctrl (NUM_PE=4). A job-level
//             model derives per-cycle expected outputs from the job timeline;
//             a negedge process compares them with the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sw_array_ctrl;

  localparam int NUM_PE    = 4;
  localparam int BP        = 2;
  localparam int DW        = 16;
  localparam int LW        = 16;
  localparam int DRAIN_CYC = NUM_PE + 2;
  localparam logic [DW-1:0] POISON = 16'hBEEF;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [LW-1:0]     len_s;
  logic [LW-1:0]     len_t;
  logic              busy;
  logic              q_valid;
  logic              q_ready;
  logic [BP-1:0]     q_base;
  logic              t_valid;
  logic              t_ready;
  logic [BP-1:0]     t_base;
  logic [NUM_PE*BP-1:0] arr_s;
  logic [NUM_PE-1:0] arr_active;
  logic              arr_valid;
  logic [BP-1:0]     arr_t;
  logic [DW-1:0]     arr_max;
  logic              result_valid;
  logic              result_ready;
  logic [DW-1:0]     result_max;
  logic              result_err;

  sw_array_ctrl #(
    .NUM_PE(NUM_PE), .BP_WIDTH(BP), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_s(len_s), .len_t(len_t),
    .busy(busy), .q_valid(q_valid), .q_ready(q_ready), .q_base(q_base),
    .t_valid(t_valid), .t_ready(t_ready), .t_base(t_base),
    .arr_s(arr_s), .arr_active(arr_active), .arr_valid(arr_valid),
    .arr_t(arr_t), .arr_max(arr_max), .result_valid(result_valid),
    .result_ready(result_ready), .result_max(result_max),
    .result_err(result_err)
  );

  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // expected outputs for the current cycle
  logic          chk_en;
  logic          exp_busy, exp_qr, exp_tr, exp_av, exp_rv, exp_rerr;
  logic [BP-1:0] exp_t;
  logic [BP-1:0] exp_slots [NUM_PE];
  logic [NUM_PE-1:0] exp_act;
  logic [DW-1:0] exp_rmax;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_PE*BP-1:0] pack_slots();
    logic [NUM_PE*BP-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_PE; i++) v[i*BP +: BP] = exp_slots[i];
    return v;
  endfunction

  // Reference Smith-Waterman score: match +2, mismatch -1, gap -1
  function automatic int sw_score(input logic [15:0] q, input int lq,
                                  input logic [15:0] t, input int lt);
    int h [0:8][0:8];
    int best;
    int v;
    best = 0;
    for (int i = 0; i <= 8; i++)
      for (int j = 0; j <= 8; j++) h[i][j] = 0;
    for (int i = 1; i <= lq; i++) begin
      for (int j = 1; j <= lt; j++) begin
        v = h[i-1][j-1] + ((q[2*(i-1) +: 2] == t[2*(j-1) +: 2]) ? 2 : -1);
        if (h[i-1][j] - 1 > v) v = h[i-1][j] - 1;
        if (h[i][j-1] - 1 > v) v = h[i][j-1] - 1;
        if (v < 0) v = 0;
        h[i][j] = v;
        if (v > best) best = v;
      end
    end
    return best;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",         32'(busy),         32'(exp_busy));
      chk("q_ready",      32'(q_ready),      32'(exp_qr));
      chk("t_ready",      32'(t_ready),      32'(exp_tr));
      chk("arr_valid",    32'(arr_valid),    32'(exp_av));
      if (exp_av) chk("arr_t", 32'(arr_t), 32'(exp_t));
      chk("arr_s",        32'(arr_s),        32'(pack_slots()));
      chk("arr_active",   32'(arr_active),   32'(exp_act));
      chk("result_valid", 32'(result_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("result_max", 32'(result_max), 32'(exp_rmax));
        chk("result_err", 32'(result_err), 32'(exp_rerr));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic b, input logic qr, input logic tr,
                         input logic av, input logic rv);
    exp_busy = b; exp_qr = qr; exp_tr = tr; exp_av = av; exp_rv = rv;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_arr_s"},        32'(arr_s),        32'h0);
    chk({tag, "_arr_active"},   32'(arr_active),   32'h0);
    chk({tag, "_arr_valid"},    32'(arr_valid),    32'h0);
    chk({tag, "_arr_t"},        32'(arr_t),        32'h0);
    chk({tag, "_q_ready"},      32'(q_ready),      32'h0);
    chk({tag, "_t_ready"},      32'(t_ready),      32'h0);
    chk({tag, "_busy"},         32'(busy),         32'h0);
    chk({tag, "_result_valid"}, 32'(result_valid), 32'h0);
    chk({tag, "_result_max"},   32'(result_max),   32'h0);
    chk({tag, "_result_err"},   32'(result_err),   32'h0);
  endtask

  // Runs one job from an IDLE cycle back to IDLE (or until an injected reset).
  task automatic run_job(input int ls, input int lt, input logic [15:0] qv,
                         input logic [15:0] tv, input int bubble_at,
                         input int rst_at, input int hold, input int peak);
    logic [DW-1:0] acc_m;
    logic          aborted;
    logic          pv;
    logic [BP-1:0] pb;
    logic [DW-1:0] w;
    bit            ok;
    ok = (ls >= 1) && (ls <= NUM_PE) && (lt >= 1);
    acc_m = '0; aborted = 1'b0; pv = 1'b0; pb = '0;

    start = 1'b1; len_s = LW'(ls); len_t = LW'(lt); arr_max = POISON;
    step();
    start = 1'b0;

    if (!ok) begin
      aborted = 1'b1;
    end else begin
      for (int k = 0; k < NUM_PE; k++) exp_slots[k] = '0;
      exp_act = '0;
      for (int k = 0; k < ls; k++) begin
        set_exp(1, 1, 0, 0, 0);
        q_valid = 1'b1; q_base = qv[2*k +: 2];
        t_valid = 1'b1; t_base = 2'b10;        // must be ignored in LOAD
        step();
        exp_slots[k] = qv[2*k +: 2];
      end
      // ARM: query complete, mask visible; stray beats must be ignored
      set_exp(1, 0, 0, 0, 0);
      exp_act = NUM_PE'((1 << ls) - 1);
      q_valid = 1'b1; q_base = 2'b11;
      step();
      for (int j = 0; j < lt; j++) begin
        set_exp(1, 0, 1, pv, 0);
        exp_t = pb;
        if (j == rst_at) begin
          t_valid = 1'b1; t_base = tv[2*j +: 2]; arr_max = POISON;
          step();
          #1 rst_n = 1'b0; chk_en = 1'b0;
          #1 check_all_zero("mid_rst");
          q_valid = 1'b0; t_valid = 1'b0; arr_max = '0;
          repeat (2) @(posedge clk);
          #1 rst_n = 1'b1;
          for (int k = 0; k < NUM_PE; k++) exp_slots[k] = '0;
          exp_act = '0;
          set_exp(0, 0, 0, 0, 0);
          chk_en = 1'b1;
          step();
          return;
        end
        w = DW'(j % 3);
        arr_max = w;
        if (w > acc_m) acc_m = w;
        if (j == bubble_at) begin
          t_valid = 1'b0; aborted = 1'b1; pv = 1'b0;
          step();
          break;
        end
        t_valid = 1'b1; t_base = tv[2*j +: 2];
        pv = 1'b1; pb = tv[2*j +: 2];
        step();
      end
      t_valid = 1'b0; q_valid = 1'b0;
      for (int d = 0; d < DRAIN_CYC; d++) begin
        set_exp(1, 0, 0, (d == 0) && pv, 0);
        exp_t = pb;
        w = (d == DRAIN_CYC - 1) ? DW'(peak) : DW'(d % 2);
        arr_max = w;
        if (w > acc_m) acc_m = w;
        step();
      end
    end

    exp_rmax = acc_m; exp_rerr = aborted;
    arr_max = POISON;
    for (int h = 0; h < hold; h++) begin
      set_exp(1, 0, 0, 0, 1);
      result_ready = 1'b0;
      start = 1'b1; len_s = 16'd1; len_t = 16'd1;   // ignored outside IDLE
      step();
    end
    set_exp(1, 0, 0, 0, 1);
    start = 1'b0; result_ready = 1'b1;
    step();
    result_ready = 1'b0; arr_max = '0;
    set_exp(0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; len_s = '0; len_t = '0;
    q_valid = 1'b0; q_base = '0; t_valid = 1'b0; t_base = '0;
    arr_max = '0; result_ready = 1'b0; chk_en = 1'b0;
    n_tests = 0; n_fail = 0;
    exp_t = '0; exp_act = '0; exp_rmax = '0; exp_rerr = 1'b0;
    for (int k = 0; k < NUM_PE; k++) exp_slots[k] = '0;
    set_exp(0, 0, 0, 0, 0);

    #3 check_all_zero("reset");
    // pin the reference scorer with hand-computed values
    chk("sw_pin_acgt",   32'(sw_score(16'h00E4, 4, 16'h00E4, 4)), 32'd8);
    chk("sw_pin_ac_gac", 32'(sw_score(16'h0004, 2, 16'h0012, 3)), 32'd4);
    chk("sw_pin_a_a",    32'(sw_score(16'h0000, 1, 16'h0000, 1)), 32'd2);

    @(posedge clk); #1 rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // ACGT vs ACGT, full array
    run_job(4, 4, 16'h00E4, 16'h00E4, -1, -1, 0, 8);
    chk("job1_result", 32'(exp_rmax), 32'd8);
    // AC vs GAC, partial mask
    run_job(2, 3, 16'h0004, 16'h0012, -1, -1, 0, 4);
    chk("job2_result", 32'(exp_rmax), 32'd4);
    // invalid lengths
    run_job(0, 3, 16'h0, 16'h0, -1, -1, 0, 0);
    run_job(5, 3, 16'h0, 16'h0, -1, -1, 0, 0);
    run_job(2, 0, 16'h0, 16'h0, -1, -1, 0, 0);
    // bubble after 2 of 6 target beats, result held 3 cycles
    run_job(4, 6, 16'h00E4, 16'h04E4, 2, -1, 3, 5);
    // reset mid-STREAM, then a clean job
    run_job(4, 4, 16'h00E4, 16'h00E4, -1, 1, 0, 8);
    run_job(2, 3, 16'h0004, 16'h0012, -1, -1, 0, 4);
    // result_ready held low for 10 cycles with start pulses in DONE
    run_job(4, 4, 16'h00E4, 16'h00E4, -1, -1, 10, 8);
    // single-base query and target
    run_job(1, 1, 16'h0000, 16'h0000, -1, -1, 0, 2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
